// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and types for the seven-segment scan scheduler.
package ssd_pkg;

    localparam int NUM_DIGITS_DEF = 4;

    // Segment patterns {g,f,e,d,c,b,a}, index 15 first.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_e;

endpackage

// File: rtl/ssd_hex_dec.sv
// ssd_hex_dec: hex nibble to active-high seven-segment pattern.
module ssd_hex_dec
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb seg = SEG_LUT[nib];

endmodule

// File: rtl/ssd_scan_sched.sv
// ssd_scan_sched: round-robin multiplexed seven-segment driver with blanking,
// PWM brightness and frame-synchronous shadow-register updates.
module ssd_scan_sched
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [4*NUM_DIGITS-1:0]   digit_val,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [3:0]                brightness,
    input  logic                      upd_req,
    output logic                      upd_ack,
    output logic [6:0]                seg,
    output logic                      seg_dp,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_start
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (BLANK_CYCLES >= REFRESH_DIV || BLANK_CYCLES == 0) begin : g_bad_blank
        $error("BLANK_CYCLES must be in 1..REFRESH_DIV-1");
    end

    logic                    run_q, run_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [3:0]              pwm_q, pwm_d;
    slot_state_e             state_q, state_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d, en_q, en_d;
    logic [3:0]              bri_q, bri_d;
    logic                    ack_q, ack_d, fs_q, fs_d, sdp_q, sdp_d;
    logic [6:0]              seg_q, seg_d, dec_seg;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic                    cnt_end, last_slot, load, on;
    logic [3:0]              nib;

    ssd_hex_dec u_dec (
        .nib (nib),
        .seg (dec_seg)
    );

    always_comb begin
        cnt_end   = cnt_q == CW'(REFRESH_DIV - 1);
        last_slot = slot_q == SW'(NUM_DIGITS - 1);
        load      = run_q && cnt_end && last_slot && upd_req;
        // Until the first post-reset edge the counters hold at zero so that
        // cycle 0 of the first frame carries frame_start.
        run_d     = 1'b1;
        cnt_d     = (!run_q || cnt_end) ? '0 : cnt_q + 1'b1;
        slot_d    = !run_q ? '0 : cnt_end ? (last_slot ? '0 : slot_q + 1'b1) : slot_q;
        state_d   = (cnt_d < CW'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;
        pwm_d     = (state_q == ST_BLANK) ? 4'd0 : pwm_q + 4'd1;
        val_d     = load ? digit_val  : val_q;
        dp_d      = load ? dp_in      : dp_q;
        en_d      = load ? digit_en   : en_q;
        bri_d     = load ? brightness : bri_q;
        nib       = val_q[{slot_d, 2'b00} +: 4];
        on        = (state_d == ST_DRIVE) && (pwm_d < bri_q) && en_q[slot_d];
        sel_d     = on ? (NUM_DIGITS'(1) << slot_d) : '0;
        seg_d     = on ? dec_seg : 7'h00;
        sdp_d     = on && dp_q[slot_d];
        fs_d      = (cnt_d == '0) && (slot_d == '0);
        ack_d     = load;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            slot_q  <= '0;
            pwm_q   <= '0;
            state_q <= ST_BLANK;
            val_q   <= '0;
            dp_q    <= '0;
            en_q    <= '0;
            bri_q   <= '0;
            ack_q   <= 1'b0;
            seg_q   <= '0;
            sdp_q   <= 1'b0;
            sel_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            run_q   <= run_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            pwm_q   <= pwm_d;
            state_q <= state_d;
            val_q   <= val_d;
            dp_q    <= dp_d;
            en_q    <= en_d;
            bri_q   <= bri_d;
            ack_q   <= ack_d;
            seg_q   <= seg_d;
            sdp_q   <= sdp_d;
            sel_q   <= sel_d;
            fs_q    <= fs_d;
        end
    end

    assign upd_ack     = ack_q;
    assign seg         = seg_q;
    assign seg_dp      = sdp_q;
    assign dig_sel     = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_sched.sv
// tb_ssd_scan_sched: frame-level reference model plus table-driven and hand-written checks.
module tb_ssd_scan_sched;

    localparam int RD = 40;
    localparam int BC = 8;
    localparam int FR = 4 * RD;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [15:0] digit_val = '0;
    logic [3:0]  dp_in = '0, digit_en = '0, brightness = '0;
    logic        upd_req = 1'b0;
    logic        upd_ack, seg_dp, frame_start;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    always #5 ACLK = ~ACLK;

    ssd_scan_sched #(.NUM_DIGITS(4), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .digit_val   (digit_val),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .brightness  (brightness),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .seg         (seg),
        .seg_dp      (seg_dp),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    typedef struct {logic [3:0] nib; logic [6:0] seg;} dec_vec_t;
    typedef struct {logic [3:0] bri; int on_cycles;} bri_vec_t;

    logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    dec_vec_t dtab [16];
    bri_vec_t btab [5];

    int checks = 0, errors = 0;
    int t;
    logic [15:0] m_val;
    logic [3:0]  m_dp, m_en, m_bri;
    logic        m_ack;
    int          on0, bad_sel, acks, fss;
    logic [6:0]  cap_seg;

    function automatic logic [6:0] dec(input logic [3:0] n);
        dec = 7'h00;
        foreach (dtab[i]) if (dtab[i].nib == n) dec = dtab[i].seg;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; m_val = '0; m_dp = '0; m_en = '0; m_bri = '0; m_ack = 1'b0;
    endtask

    // One clock cycle: compare all outputs against the model, then advance it.
    task automatic cyc();
        int fc, sl, cn;
        logic on;
        logic [13:0] exp, act;
        @(negedge ACLK);
        fc = t % FR;
        sl = fc / RD;
        cn = fc % RD;
        on = (cn >= BC) && (((cn - BC) % 16) < int'(m_bri)) && m_en[sl];
        exp = {m_ack, on ? dec(m_val[sl*4 +: 4]) : 7'h00, on & m_dp[sl],
               on ? 4'(1 << sl) : 4'h0, fc == 0};
        act = {upd_ack, seg, seg_dp, dig_sel, frame_start};
        check($sformatf("cycle %0d {ack,seg,dp,sel,fs}", t), 32'(act), 32'(exp));
        if (sl == 0 && dig_sel != 0) on0++;
        if (dig_sel == 4'b0001 || dig_sel == 4'b0100) bad_sel++;
        acks += int'(upd_ack);
        fss  += int'(frame_start);
        if (sl == 0 && cn == BC) cap_seg = seg;
        m_ack = (fc == FR - 1) && upd_req;
        if (m_ack) begin
            m_val = digit_val; m_dp = dp_in; m_en = digit_en; m_bri = brightness;
        end
        t++;
        @(posedge ACLK);
        #1;
    endtask

    // req_fc: frame cycle where upd_req is high; -1 never, -2 always.
    task automatic frame(input int req_fc);
        on0 = 0; bad_sel = 0; acks = 0; fss = 0; cap_seg = 7'h00;
        for (int i = 0; i < FR; i++) begin
            upd_req = (req_fc == -2) || (i == req_fc);
            cyc();
        end
        upd_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) dtab[i] = '{4'(i), pats[i]};
        btab = '{'{4'd0, 0}, '{4'd1, 2}, '{4'd4, 8}, '{4'd8, 16}, '{4'd15, 30}};

        digit_val = 16'hFFFF; dp_in = 4'hF; digit_en = 4'hF; brightness = 4'hF; upd_req = 1'b1;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("reset outputs", 32'({upd_ack, seg, seg_dp, dig_sel, frame_start}), 32'h0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1; upd_req = 1'b0;
        @(posedge ACLK); #1;
        model_reset();

        frame(-1);
        check("idle frame fs count", fss, 1);
        check("idle frame sel count", on0, 0);

        digit_val = 16'h5C1E; dp_in = 4'b0011; digit_en = 4'h5; brightness = 4'd6;
        frame(-2);
        digit_val = 16'h8A30; dp_in = 4'b0100; digit_en = 4'hF; brightness = 4'd15;
        frame(-2);
        check("held req ack per frame", acks, 1);
        frame(-1);
        check("reload ack", acks, 1);
        check("b15 slot0 on cycles", on0, 30);
        check("digit0 seg 0", cap_seg, 7'h3F);
        frame(-1);
        check("no ack without req", acks, 0);

        foreach (dtab[i]) begin
            digit_val = {4{dtab[i].nib}}; dp_in = 4'h0; digit_en = 4'hF; brightness = 4'd15;
            frame(FR - 1);
            frame(-1);
            check($sformatf("decode %h", dtab[i].nib), cap_seg, dtab[i].seg);
            check($sformatf("boundary ack %h", dtab[i].nib), acks, 1);
        end

        foreach (btab[i]) begin
            digit_val = 16'($urandom); dp_in = 4'($urandom); digit_en = 4'hF; brightness = btab[i].bri;
            frame(FR - 1);
            frame(-1);
            check($sformatf("bri %0d on cycles", btab[i].bri), on0, btab[i].on_cycles);
        end

        digit_val = 16'h1234; dp_in = 4'hF; digit_en = 4'b1010; brightness = 4'd15;
        frame(FR - 1);
        frame(-1);
        check("en1010 forbidden sel", bad_sel, 0);
        check("en1010 fs per frame", fss, 1);

        digit_en = 4'hF; brightness = 4'd9;
        frame(50);
        frame(-1);
        check("mid-frame req ack", acks, 0);
        check("mid-frame req no load", on0, 0);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < FR; i++) begin
                digit_val = 16'($urandom); dp_in = 4'($urandom);
                digit_en = 4'($urandom); brightness = 4'($urandom);
                upd_req = (i == FR - 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
                cyc();
            end
        end
        upd_req = 1'b0;

        digit_val = 16'h1234; dp_in = 4'b0100; digit_en = 4'hF; brightness = 4'd15;
        frame(FR - 1);
        for (int i = 0; i < 2 * RD + 20; i++) cyc();
        #2;
        check("pre-reset sel slot2", dig_sel, 4'b0100);
        ARESETN = 1'b0; upd_req = 1'b1;
        #1;
        check("async reset outputs", 32'({upd_ack, seg, seg_dp, dig_sel, frame_start}), 32'h0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("held reset outputs", 32'({upd_ack, seg, seg_dp, dig_sel, frame_start}), 32'h0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1; upd_req = 1'b0;
        @(posedge ACLK); #1;
        model_reset();
        frame(-1);
        check("post-reset fs count", fss, 1);
        check("post-reset shadow clear", on0, 0);
        frame(-1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_sched.md
SSD_SCAN_SCHED -- requirements
Module: ssd_scan_sched

Interface
REQ-001 Parameters SHALL be:
- NUM_DIGITS, 4: digit slots per frame.
- REFRESH_DIV, 50000: ACLK cycles per slot.
- BLANK_CYCLES, 200: blanked cycles at the start of each slot.
REQ-002 Ports SHALL be (clock and reset first):
- ACLK  in  1: sole clock.
- ARESETN  in  1: reset; asynchronous assert, active-low.
- digit_val  in  16: hex nibble per digit; digit i = bits [4i+3:4i].
- dp_in  in  4: decimal point per digit.
- digit_en  in  4: per-digit enable.
- brightness  in  4: PWM duty code.
- upd_req  in  1: level request to load a new shadow set.
- upd_ack  out  1: one-cycle grant pulse.
- seg  out  7: active-high segments {g,f,e,d,c,b,a}.
- seg_dp  out  1: active-high decimal point.
- dig_sel  out  4: one-hot active-high digit select.
- frame_start  out  1: one-cycle pulse at the first cycle of slot 0.

Function
REQ-003 The block SHALL time-share the seg/seg_dp bus among NUM_DIGITS digits in fixed round-robin order 0,1,2,3,0,...
REQ-004 A slot counter SHALL count 0..REFRESH_DIV-1; at REFRESH_DIV-1 it SHALL wrap to 0 and advance the slot index, which wraps from 3 to 0.
REQ-005 Per-slot FSM states SHALL be:
- BLANK (slot_cnt < BLANK_CYCLES): dig_sel=0, seg=0, seg_dp=0.
- DRIVE: all other cycles of the slot.
- Transitions occur only on slot_cnt thresholds.
REQ-006 In DRIVE, a 4-bit pwm_cnt SHALL reset to 0 on DRIVE entry and increment every cycle, wrapping at 15.
REQ-007 While pwm_cnt < shadow brightness (4-bit unsigned compare), dig_sel SHALL be one-hot for the current slot, and seg/seg_dp SHALL show the decoded shadow nibble and dp. Otherwise dig_sel, seg and seg_dp SHALL be 0.
REQ-008 Brightness 0 SHALL blank permanently; brightness 15 SHALL give 15/16 duty within DRIVE.
REQ-009 A slot whose shadow digit_en bit is 0 SHALL keep full slot duration with all outputs 0, so the frame period stays constant.
REQ-010 All outputs SHALL be registers updated on the same ACLK edge as the counters; dig_sel first asserts in the cycle where slot_cnt==BLANK_CYCLES.
REQ-011 Shadow registers SHALL hold digit_val, dp_in, digit_en and brightness. They SHALL load only on the frame-boundary edge (slot 3, slot_cnt==REFRESH_DIV-1) and only if upd_req=1 in that cycle. On that load, upd_ack SHALL pulse high for the following cycle.
REQ-012 upd_req asserting in the boundary cycle itself SHALL be accepted. upd_req held across multiple boundaries SHALL reload and ack each frame. Inputs SHALL be sampled only at load time.
REQ-013 The hex decode SHALL use standard 0-F patterns, e.g. 0->7'h3F, 8->7'h7F, A->7'h77, F->7'h71.
REQ-014 frame_start SHALL be 1 exactly in the first cycle of slot 0, including the first frame after reset.
REQ-015 Elaboration SHALL fail if BLANK_CYCLES >= REFRESH_DIV or BLANK_CYCLES == 0.

Reset
REQ-016 ARESETN=0 SHALL immediately clear all counters, the slot index, the FSM (to BLANK), shadow registers and every output to 0, including mid-slot or mid-DRIVE.
REQ-017 upd_req during reset SHALL be ignored. The first cycle after ARESETN deasserts SHALL be slot 0, slot_cnt 0, with frame_start=1.

Structure
REQ-018 Package ssd_pkg SHALL hold the 16-entry segment pattern constant, the slot FSM enum and the NUM_DIGITS default.
REQ-019 Combinational sub-module ssd_hex_dec (nibble in, 7-bit seg out) SHALL implement the decode. Everything else stays in ssd_scan_sched.

Verification (REFRESH_DIV=40, BLANK_CYCLES=8)
REQ-020 Reset release, upd_req=0 -> all outputs 0 for a full 160-cycle frame; frame_start pulses at cycles 0 and 160.
REQ-021 upd_req=1 with digit_val=16'h8A30, digit_en=4'hF, brightness=15, dp_in=4'b0100 -> upd_ack pulses once after cycle 159. Next frame: digit0 seg=7'h3F, digit1 seg=7'h4F, digit2 seg=7'h77 with seg_dp=1, digit3 seg=7'h7F. dig_sel is high 15 of every 16 DRIVE cycles, starting at slot_cnt=8.
REQ-022 brightness=4 -> per slot, dig_sel high for pwm_cnt 0-3 only, i.e. 8 of 32 DRIVE cycles. brightness=0 -> dig_sel never asserts.
REQ-023 digit_en=4'b1010 -> dig_sel never equals 4'b0001 or 4'b0100; frame period remains 160 cycles.
REQ-024 upd_req pulsed for 1 cycle mid-frame -> no load, no upd_ack. upd_req first high at a boundary cycle -> load and upd_ack next cycle.
REQ-025 ARESETN dropped at slot 2, slot_cnt=20 -> outputs and shadow 0 in the same cycle. After release, frame_start=1 and scanning restarts at slot 0.
